seq_detect_fsm: RTL and testbench
=================================

Name: seq_detect_fsm

Overview:
- Parametrised serial pattern-detector state machine; next generation of the team's basic fixed 4-state, 1-bit-input FSM.
- Scans a 1-bit input stream for a configurable LEN-bit pattern.
- Supports overlapping/non-overlapping detection, an optional post-match hold window, and a saturating match counter.
- Sits between a serial input source and downstream logic that consumes single-cycle match pulses.

Parameters:
- LEN, 4: pattern length in bits, 2..16.
- PATTERN, 4'b1011: target pattern; MSB is the first bit received.
- OVERLAP, 1: 1 = after a match, keep the longest proper border of PATTERN; 0 = restart from 0.
- HOLD, 0: number of en-qualified cycles after a match during which din is ignored; 0..255.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  sample enable; din is consumed only on cycles with en=1.
- din  in  1  serial data bit.
- clr  in  1  synchronous clear of progress, FSM and counters.
- match  out  1  one-cycle pulse, registered.
- busy  out  1  high while in the HOLD state.
- progress  out  $clog2(LEN+1)  number of pattern bits currently matched (0..LEN-1).
- match_cnt  out  CNT_W  saturating count of matches.
- overflow  out  1  sticky; set when a match occurs with match_cnt at all-ones.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low. rst_n=0 forces immediately: state=SCAN, progress=0, hold counter=0, match=0, busy=0, match_cnt=0, overflow=0.
- Priority per rising edge: clr > en=0 > normal operation.
  - clr=1: same values as reset, applied synchronously; a match in that cycle is discarded.
  - en=0: all state frozen; match forced to 0.
- FSM states: SCAN and HOLD.
- SCAN, en=1, progress p:
  - If din == PATTERN[LEN-1-p], then p_next = p+1.
  - Otherwise p_next = length of the longest prefix of PATTERN that is a suffix of (the matched prefix followed by din). This is a KMP fallback and may be 0.
  - Derive the fallback table from PATTERN at elaboration (function/generate); do not hand-code it.
- Match condition: p_next == LEN.
  - On the next edge: match=1 for exactly one cycle; match_cnt increments unless all-ones.
  - If match_cnt is already all-ones: match_cnt holds and overflow is set.
  - If HOLD==0: stay in SCAN; progress = border length of PATTERN when OVERLAP=1, else 0.
  - If HOLD>0: go to HOLD; progress=0; hold counter loads HOLD; OVERLAP is ignored.
- HOLD:
  - busy=1.
  - Each en=1 cycle decrements the hold counter; din is ignored.
  - When the counter reaches 0 on an en=1 edge, return to SCAN with progress=0. The first bit sampled back in SCAN is the bit of the edge after that.
  - HOLD lasts exactly HOLD en-qualified cycles.
- Latency: match is asserted in the cycle immediately following the edge that samples the final pattern bit.
- match is never high on two consecutive cycles unless OVERLAP=1 and the pattern allows a match every bit (e.g. all-ones pattern with border LEN-1). That case is legal and must pulse each cycle.
- Simultaneous clr and a completing bit: clr wins, no match, no count.
- Reset deasserted mid-stream: detection starts fresh from progress=0.

Test Plan (defaults LEN=4, PATTERN=1011 unless stated):
1. Reset: assert rst_n=0 mid-pattern (progress=3) asynchronously → all outputs 0 before the next clk edge. After release: progress=0, match_cnt=0.
2. Overlap: OVERLAP=1, HOLD=0, en=1, din=1,0,1,1,0,1,1 → match pulses after bits 4 and 7; progress=1 after each match; match_cnt=2.
3. Non-overlap and KMP fallback:
   - OVERLAP=0, same stream → single match after bit 4; progress after bits 5..7 = 0,1,1; match_cnt=1.
   - Then clr; din=1,0,1,0,1,1 → progress 1,2,3,2,3, then match after bit 6.
4. Hold: HOLD=2, din=1,0,1,1,1,0,1,1 → match after bit 4; busy=1 while bits 5–6 are sampled; bits 7–8 give progress 1,1; match_cnt=1.
5. Enable gating: din=1,0 (en=1), then 3 cycles en=0 with din toggling, then din=1,1 (en=1) → progress holds at 2 during the gap; match after the final bit; match stays 0 while en=0.
6. Saturation: CNT_W=2, drive 5 non-overlapping matches → match_cnt=3 after the 3rd match; overflow=1 after the 4th; a clr pulse → match_cnt=0, overflow=0, progress=0.

Source files
------------

// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
//
// Serial pattern detector. It scans a 1-bit stream for a LEN-bit PATTERN,
// with the MSB of PATTERN received first. A partial mismatch falls back along
// a KMP failure table. That table is derived from PATTERN at elaboration time,
// so changing PATTERN needs no hand edits.
// After a match the detector does one of two things:
//   - keeps the longest proper border (OVERLAP=1) or restarts (OVERLAP=0), or
//   - enters a HOLD window of HOLD enabled cycles in which din is ignored.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : sample enable; din consumed only when en=1
//   din       : serial data bit
//   clr       : synchronous clear of FSM, progress and counters (beats en)
//   match     : registered single-cycle match pulse
//   busy      : high while in HOLD
//   progress  : number of pattern bits currently matched (0..LEN-1)
//   match_cnt : saturating match counter
//   overflow  : sticky, set by a match while match_cnt is all-ones
// -----------------------------------------------------------------------------
module seq_detect_fsm #(
  parameter int               LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               HOLD    = 0,
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       din,
  input  logic                       clr,
  output logic                       match,
  output logic                       busy,
  output logic [$clog2(LEN+1)-1:0]   progress,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       overflow
);

  localparam int PW = $clog2(LEN+1);

  typedef enum logic {
    SCAN = 1'b0,
    HOLD_ST = 1'b1
  } state_t;

  // Length of the longest prefix of PATTERN that is a suffix of
  // (first p pattern bits followed by b). A result of p+1 means b extended the match.
  function automatic int kmp_next(input int p, input int b);
    int   result;
    logic ok;
    logic s_bit;
    result = 0;
    for (int k = p + 1; k >= 1; k--) begin
      if (result == 0) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          s_bit = ((p + 1 - k + i) < p) ? PATTERN[LEN-1-(p+1-k+i)] : b[0];
          if (PATTERN[LEN-1-i] != s_bit) ok = 1'b0;
        end
        if (ok) result = k;
      end
    end
    return result;
  endfunction

  // Longest proper border of the whole pattern, used as restart point on overlap.
  function automatic int border_len();
    int   result;
    logic ok;
    result = 0;
    for (int k = LEN - 1; k >= 1; k--) begin
      if (result == 0) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          if (PATTERN[LEN-1-i] != PATTERN[k-1-i]) ok = 1'b0;
        end
        if (ok) result = k;
      end
    end
    return result;
  endfunction

  localparam logic [PW-1:0] LEN_P    = PW'(LEN);
  localparam logic [PW-1:0] BORDER_P = PW'(border_len());
  localparam logic [7:0]    HOLD_P   = 8'(HOLD);

  // The table is sized to the full index range of progress so that any index
  // is in range. Rows at LEN and above are never reached, so they are padded with zeros.
  logic [PW-1:0] next_tab [2**PW][2];

  for (genvar gp = 0; gp < 2**PW; gp++) begin : g_tab
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      if (gp < LEN) begin : g_live
        localparam int NXT = kmp_next(gp, gb);
        assign next_tab[gp][gb] = PW'(NXT);
      end else begin : g_pad
        assign next_tab[gp][gb] = '0;
      end
    end
  end

  state_t            state_q, state_d;
  logic [PW-1:0]     prog_q, prog_d;
  logic [7:0]        hold_q, hold_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     p_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      prog_q  <= '0;
      hold_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      hold_q  <= hold_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    hold_d  = hold_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    p_next  = next_tab[prog_q][din];

    if (clr) begin
      state_d = SCAN;
      prog_d  = '0;
      hold_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      case (state_q)
        SCAN: begin
          if (p_next == LEN_P) begin
            match_d = 1'b1;
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
            if (HOLD == 0) begin
              prog_d = (OVERLAP != 0) ? BORDER_P : '0;
            end else begin
              state_d = HOLD_ST;
              prog_d  = '0;
              hold_d  = HOLD_P;
            end
          end else begin
            prog_d = p_next;
          end
        end
        HOLD_ST: begin
          hold_d = hold_q - 8'd1;
          if (hold_q == 8'd1) state_d = SCAN;
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign match     = match_q;
  assign busy      = (state_q == HOLD_ST);
  assign progress  = prog_q;
  assign match_cnt = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_fsm
//
// Directed bench for seq_detect_fsm. Five instances share one stimulus stream:
//   u_ovl  : defaults (1011, overlap, no hold)
//   u_novl : OVERLAP=0
//   u_hold : HOLD=2
//   u_sat  : CNT_W=2, OVERLAP=0
//   u_ones : LEN=3, PATTERN=111, overlap (a match on every bit)
// Each scenario starts with a clr, so earlier traffic does not leak into it.
// -----------------------------------------------------------------------------
module tb_seq_detect_fsm;

  logic clk;
  logic rst_n;
  logic en;
  logic din;
  logic clr;

  logic       a_match, a_busy, a_ovf;
  logic [2:0] a_prog;
  logic [7:0] a_cnt;

  logic       b_match, b_busy, b_ovf;
  logic [2:0] b_prog;
  logic [7:0] b_cnt;

  logic       h_match, h_busy, h_ovf;
  logic [2:0] h_prog;
  logic [7:0] h_cnt;

  logic       s_match, s_busy, s_ovf;
  logic [2:0] s_prog;
  logic [1:0] s_cnt;

  logic       o_match, o_busy, o_ovf;
  logic [1:0] o_prog;
  logic [7:0] o_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_detect_fsm u_ovl (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(a_match), .busy(a_busy), .progress(a_prog),
    .match_cnt(a_cnt), .overflow(a_ovf)
  );

  seq_detect_fsm #(.OVERLAP(0)) u_novl (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(b_match), .busy(b_busy), .progress(b_prog),
    .match_cnt(b_cnt), .overflow(b_ovf)
  );

  seq_detect_fsm #(.HOLD(2)) u_hold (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(h_match), .busy(h_busy), .progress(h_prog),
    .match_cnt(h_cnt), .overflow(h_ovf)
  );

  seq_detect_fsm #(.OVERLAP(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(s_match), .busy(s_busy), .progress(s_prog),
    .match_cnt(s_cnt), .overflow(s_ovf)
  );

  seq_detect_fsm #(.LEN(3), .PATTERN(3'b111)) u_ones (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(o_match), .busy(o_busy), .progress(o_prog),
    .match_cnt(o_cnt), .overflow(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven at the falling edge. Outputs are read at the next falling
  // edge, after one rising edge has consumed the inputs.
  task automatic cycle(input logic d, input logic e, input logic c);
    din = d;
    en  = e;
    clr = c;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    bit [5:0] seq = 6'b101101;
    if ({a_match, a_busy, a_prog, a_cnt, a_ovf} !== 13'd0) begin
      $display("[TB] FAIL reset_init: got %h expected 0", {a_match, a_busy, a_prog, a_cnt, a_ovf});
    end else pass_cnt++;
    total_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(seq[5-i], 1'b1, 1'b0);
    if (a_prog !== 3'd3 || a_cnt !== 8'd1) begin
      $display("[TB] FAIL reset_pre: got prog=%0d cnt=%0d expected prog=3 cnt=1", a_prog, a_cnt);
    end else pass_cnt++;
    total_cnt++;
    #2 rst_n = 1'b0;
    #1;
    if ({a_match, a_busy, a_prog, a_cnt, a_ovf} !== 13'd0) begin
      $display("[TB] FAIL reset_async: got %h expected 0", {a_match, a_busy, a_prog, a_cnt, a_ovf});
    end else pass_cnt++;
    total_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    if (a_prog !== 3'd0 || a_cnt !== 8'd0) begin
      $display("[TB] FAIL reset_release: got prog=%0d cnt=%0d expected 0 0", a_prog, a_cnt);
    end else pass_cnt++;
    total_cnt++;
    cycle(1'b1, 1'b1, 1'b0);
    if (a_prog !== 3'd1) begin
      $display("[TB] FAIL reset_fresh: got prog=%0d expected 1", a_prog);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_overlap();
    bit [6:0] seq = 7'b1011011;
    bit [6:0] em  = 7'b0001001;
    int       ep [7] = '{1, 2, 3, 1, 2, 3, 1};
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(seq[6-i], 1'b1, 1'b0);
      if (a_match !== em[6-i] || a_prog !== 3'(ep[i])) begin
        $display("[TB] FAIL overlap_bit%0d: got match=%b prog=%0d expected match=%b prog=%0d",
                 i + 1, a_match, a_prog, em[6-i], ep[i]);
      end else pass_cnt++;
      total_cnt++;
    end
    if (a_cnt !== 8'd2) begin
      $display("[TB] FAIL overlap_cnt: got %0d expected 2", a_cnt);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_non_overlap();
    bit [6:0] seq  = 7'b1011011;
    bit [6:0] em   = 7'b0001000;
    int       ep [7] = '{1, 2, 3, 0, 0, 1, 1};
    bit [5:0] seq2 = 6'b101011;
    bit [5:0] em2  = 6'b000001;
    int       ep2 [6] = '{1, 2, 3, 2, 3, 0};
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(seq[6-i], 1'b1, 1'b0);
      if (b_match !== em[6-i] || b_prog !== 3'(ep[i])) begin
        $display("[TB] FAIL novl_bit%0d: got match=%b prog=%0d expected match=%b prog=%0d",
                 i + 1, b_match, b_prog, em[6-i], ep[i]);
      end else pass_cnt++;
      total_cnt++;
    end
    if (b_cnt !== 8'd1) begin
      $display("[TB] FAIL novl_cnt: got %0d expected 1", b_cnt);
    end else pass_cnt++;
    total_cnt++;
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(seq2[5-i], 1'b1, 1'b0);
      if (b_match !== em2[5-i] || b_prog !== 3'(ep2[i])) begin
        $display("[TB] FAIL kmp_bit%0d: got match=%b prog=%0d expected match=%b prog=%0d",
                 i + 1, b_match, b_prog, em2[5-i], ep2[i]);
      end else pass_cnt++;
      total_cnt++;
    end
  endtask

  task automatic test_hold();
    bit [7:0] seq = 8'b10111011;
    bit [7:0] eb  = 8'b00011000;
    bit [7:0] em  = 8'b00010000;
    int       ep [8] = '{1, 2, 3, 0, 0, 0, 1, 1};
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(seq[7-i], 1'b1, 1'b0);
      if (h_match !== em[7-i] || h_busy !== eb[7-i] || h_prog !== 3'(ep[i])) begin
        $display("[TB] FAIL hold_bit%0d: got match=%b busy=%b prog=%0d expected match=%b busy=%b prog=%0d",
                 i + 1, h_match, h_busy, h_prog, em[7-i], eb[7-i], ep[i]);
      end else pass_cnt++;
      total_cnt++;
    end
    if (h_cnt !== 8'd1) begin
      $display("[TB] FAIL hold_cnt: got %0d expected 1", h_cnt);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_enable();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (a_prog !== 3'd2 || a_match !== 1'b0) begin
        $display("[TB] FAIL enable_gap%0d: got prog=%0d match=%b expected prog=2 match=0",
                 i, a_prog, a_match);
      end else pass_cnt++;
      total_cnt++;
    end
    cycle(1'b1, 1'b1, 1'b0);
    if (a_prog !== 3'd3 || a_match !== 1'b0) begin
      $display("[TB] FAIL enable_bit3: got prog=%0d match=%b expected prog=3 match=0", a_prog, a_match);
    end else pass_cnt++;
    total_cnt++;
    cycle(1'b1, 1'b1, 1'b0);
    if (a_match !== 1'b1 || a_prog !== 3'd1 || a_cnt !== 8'd1) begin
      $display("[TB] FAIL enable_match: got match=%b prog=%0d cnt=%0d expected 1 1 1",
               a_match, a_prog, a_cnt);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_saturation();
    bit [3:0]   pat = 4'b1011;
    logic [1:0] exp_cnt;
    logic       exp_ovf;
    cycle(1'b0, 1'b1, 1'b1);
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) cycle(pat[3-i], 1'b1, 1'b0);
      exp_cnt = (m < 3) ? 2'(m + 1) : 2'd3;
      exp_ovf = (m >= 3);
      if (s_match !== 1'b1 || s_cnt !== exp_cnt || s_ovf !== exp_ovf) begin
        $display("[TB] FAIL sat_match%0d: got match=%b cnt=%0d ovf=%b expected match=1 cnt=%0d ovf=%b",
                 m + 1, s_match, s_cnt, s_ovf, exp_cnt, exp_ovf);
      end else pass_cnt++;
      total_cnt++;
    end
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    if (s_cnt !== 2'd0 || s_ovf !== 1'b0 || s_prog !== 3'd0) begin
      $display("[TB] FAIL sat_clr: got cnt=%0d ovf=%b prog=%0d expected 0 0 0", s_cnt, s_ovf, s_prog);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_back_to_back();
    bit [4:0] em = 5'b00111;
    int       ep [5] = '{1, 2, 2, 2, 2};
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (o_match !== em[4-i] || o_prog !== 2'(ep[i])) begin
        $display("[TB] FAIL ones_bit%0d: got match=%b prog=%0d expected match=%b prog=%0d",
                 i + 1, o_match, o_prog, em[4-i], ep[i]);
      end else pass_cnt++;
      total_cnt++;
    end
    if (o_cnt !== 8'd3) begin
      $display("[TB] FAIL ones_cnt: got %0d expected 3", o_cnt);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_clr_priority();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    if (a_match !== 1'b0 || a_cnt !== 8'd0 || a_prog !== 3'd0) begin
      $display("[TB] FAIL clr_win: got match=%b cnt=%0d prog=%0d expected 0 0 0", a_match, a_cnt, a_prog);
    end else pass_cnt++;
    total_cnt++;
    cycle(1'b1, 1'b1, 1'b0);
    if (a_match !== 1'b0 || a_prog !== 3'd1) begin
      $display("[TB] FAIL clr_after: got match=%b prog=%0d expected 0 1", a_match, a_prog);
    end else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_overlap();
    test_non_overlap();
    test_hold();
    test_enable();
    test_saturation();
    test_back_to_back();
    test_clr_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
